// File: rtl/ex_div_unit.sv
// Restoring divider recovering A = (S - C) / B from an ex_top result, one quotient bit per clock.
// Optional reconstruction self-check enabled by defining EX_DIV_CHECK_EN.
module ex_div_unit #(
    parameter int DW = 8,
    parameter int BW = 4
) (
    input  logic          clk,
    input  logic          clear_n,
    input  logic          start,
    input  logic [DW-1:0] S,
    input  logic [DW-1:0] C,
    input  logic [BW-1:0] B,
    output logic          busy,
    output logic          done,
    output logic [DW-1:0] Q,
    output logic [BW-1:0] R,
    output logic          div_zero,
    output logic          underflow,
    output logic          chk_err
);

    localparam int CW = $clog2(DW);

    typedef enum logic [1:0] {IDLE, PREP, DIV} state_t;

    state_t        state;
    logic [DW-1:0] s_reg, c_reg, sh;
    logic [BW-1:0] b_reg, p;
    logic [CW-1:0] cnt;

    logic [BW:0]   p_shift, trial;
    logic          q_bit;
    logic [BW-1:0] p_next;
    logic [DW-1:0] q_next;
    logic          chk_fail;

    // One restoring step: a negative trial shows up as a set top bit.
    always_comb begin
        p_shift = {p, sh[DW-1]};
        trial   = p_shift - {1'b0, b_reg};
        q_bit   = ~trial[BW];
        p_next  = q_bit ? trial[BW-1:0] : p_shift[BW-1:0];
        q_next  = {sh[DW-2:0], q_bit};
    end

`ifdef EX_DIV_CHECK_EN
    localparam int XW = DW + BW + 1;
    logic [XW-1:0] recon;

    always_comb begin
        recon    = XW'(q_next) * XW'(b_reg) + XW'(p_next) + XW'(c_reg);
        chk_fail = (recon != XW'(s_reg));
    end
`else
    assign chk_fail = 1'b0;
`endif

    // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            state     <= IDLE;
            s_reg     <= '0;
            c_reg     <= '0;
            b_reg     <= '0;
            sh        <= '0;
            p         <= '0;
            cnt       <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            Q         <= '0;
            R         <= '0;
            div_zero  <= 1'b0;
            underflow <= 1'b0;
            chk_err   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        s_reg     <= S;
                        c_reg     <= C;
                        b_reg     <= B;
                        busy      <= 1'b1;
                        div_zero  <= 1'b0;
                        underflow <= 1'b0;
                        chk_err   <= 1'b0;
                        state     <= PREP;
                    end
                end
                PREP: begin
                    // Divide-by-zero wins over underflow when both apply.
                    if (b_reg == '0) begin
                        div_zero <= 1'b1;
                        Q        <= '1;
                        R        <= '0;
                        done     <= 1'b1;
                        busy     <= 1'b0;
                        state    <= IDLE;
                    end else if (s_reg < c_reg) begin
                        underflow <= 1'b1;
                        Q         <= '0;
                        R         <= '0;
                        done      <= 1'b1;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end else begin
                        p     <= '0;
                        sh    <= s_reg - c_reg;
                        cnt   <= CW'(DW - 1);
                        state <= DIV;
                    end
                end
                DIV: begin
                    p   <= p_next;
                    sh  <= q_next;
                    cnt <= cnt - 1'b1;
                    if (cnt == '0) begin
                        Q       <= q_next;
                        R       <= p_next;
                        chk_err <= chk_fail;
                        done    <= 1'b1;
                        busy    <= 1'b0;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
